// File: rtl/pcie_7x_v1_11_0_drp_pkg.sv
// Shared types and constants for the DRP responder: FSM encoding, bus widths,
// error bit positions, LFSR seed/taps and default latencies.
// No logic; no backpressure.
package pcie_7x_v1_11_0_drp_pkg;

    localparam int DRP_ADDR_W = 8;
    localparam int DRP_DATA_W = 16;

    localparam int ERR_BUSY = 0;
    localparam int ERR_ADDR = 1;
    localparam int ERR_RO   = 2;
    localparam int ERR_W    = 3;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8+x^6+x^5+x^4+1 on a left-shifting register: bits 7,5,4,3 feed back
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    localparam logic [3:0] DEF_RD_LATENCY = 4'd3;
    localparam logic [3:0] DEF_WR_LATENCY = 4'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } drp_state_e;

    function automatic logic [3:0] lat_sat_add(input logic [3:0] base, input logic [1:0] extra);
        logic [4:0] sum;
        sum = {1'b0, base} + {3'b000, extra};
        return sum[4] ? 4'hF : sum[3:0];
    endfunction

endpackage

// File: rtl/pcie_7x_v1_11_0_drp_resp_lat.sv
// Latency timer: loads on request acceptance, flags direct (latency 1) and expiry.
// Latency: combinational strobes from the registered count.
// Backpressure: none; the FSM only loads it when idle. Random extra latency with DRP_RESP_RAND_LAT_EN.
module pcie_7x_v1_11_0_drp_resp_lat
    import pcie_7x_v1_11_0_drp_pkg::*;
#(
    parameter logic [3:0] RD_LATENCY = DEF_RD_LATENCY,
    parameter logic [3:0] WR_LATENCY = DEF_WR_LATENCY
) (
    input  logic DRP_CLK,
    input  logic DRP_RST_N,
    input  logic lat_load,
    input  logic lat_we,
    input  logic lat_wait,
    output logic lat_direct,
    output logic lat_expire
);

    logic [3:0] base_lat;
    logic [3:0] eff_lat;
    logic [3:0] cnt_q;

    assign base_lat = lat_we ? WR_LATENCY : RD_LATENCY;

`ifdef DRP_RESP_RAND_LAT_EN
    logic [7:0] lfsr_q;

    always_ff @(posedge DRP_CLK or negedge DRP_RST_N) begin
        if (!DRP_RST_N) lfsr_q <= LFSR_SEED;
        else            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    assign eff_lat = lat_sat_add(base_lat, lfsr_q[1:0]);
`else
    assign eff_lat = base_lat;
`endif

    assign lat_direct = (eff_lat <= 4'd1);
    // Count holds cycles still to go including the RESP cycle; 1 means RESP is next.
    assign lat_expire = lat_wait && (cnt_q <= 4'd1);

    always_ff @(posedge DRP_CLK or negedge DRP_RST_N) begin
        if (!DRP_RST_N)                   cnt_q <= 4'd0;
        else if (lat_load)                cnt_q <= eff_lat - 4'd1;
        else if (lat_wait && cnt_q != 0)  cnt_q <= cnt_q - 4'd1;
    end

endmodule

// File: rtl/pcie_7x_v1_11_0_drp_resp.sv
// DRP responder: soft register bank plus read-only CRS status word, with protocol error flags.
// Latency: DRP_RDY at RD_LATENCY/WR_LATENCY cycles after DRP_EN (randomised with DRP_RESP_RAND_LAT_EN).
// Backpressure: one transaction at a time; DRP_EN while busy is dropped and flagged in DRP_ERR[0].
module pcie_7x_v1_11_0_drp_resp
    import pcie_7x_v1_11_0_drp_pkg::*;
#(
    parameter logic [7:0] BASE_ADDR  = 8'h30,
    parameter int         DEPTH      = 16,
    parameter logic [7:0] RO_ADDR    = 8'h88,
    parameter logic [3:0] RD_LATENCY = DEF_RD_LATENCY,
    parameter logic [3:0] WR_LATENCY = DEF_WR_LATENCY
) (
    input  logic                  DRP_CLK,
    input  logic                  DRP_RST_N,
    input  logic                  DRP_EN,
    input  logic                  DRP_WE,
    input  logic [DRP_ADDR_W-1:0] DRP_ADDR,
    input  logic [DRP_DATA_W-1:0] DRP_DI,
    output logic [DRP_DATA_W-1:0] DRP_DO,
    output logic                  DRP_RDY,
    input  logic [5:0]            STAT_CRSCODE,
    input  logic                  ERR_CLR,
    output logic [ERR_W-1:0]      DRP_ERR,
    output logic                  DRP_BUSY
);

    localparam int         IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int         BANK_N = 1 << IDX_W;
    localparam logic [7:0] DEPTH8 = 8'(DEPTH);

    drp_state_e state_q, state_d;

    logic [DRP_ADDR_W-1:0] addr_q;
    logic [DRP_DATA_W-1:0] di_q;
    logic                  we_q;
    logic [DRP_DATA_W-1:0] do_q;
    logic [ERR_W-1:0]      err_q;
    logic [DRP_DATA_W-1:0] bank [BANK_N];

    logic                  accept;
    logic                  in_resp;
    logic                  lat_load;
    logic                  lat_direct;
    logic                  lat_expire;
    logic [7:0]            addr_off;
    logic [IDX_W-1:0]      idx;
    logic                  is_ro;
    logic                  in_win;
    logic [DRP_DATA_W-1:0] rd_val;
    logic [ERR_W-1:0]      err_set;

    pcie_7x_v1_11_0_drp_resp_lat #(
        .RD_LATENCY (RD_LATENCY),
        .WR_LATENCY (WR_LATENCY)
    ) u_lat (
        .DRP_CLK    (DRP_CLK),
        .DRP_RST_N  (DRP_RST_N),
        .lat_load   (lat_load),
        .lat_we     (DRP_WE),
        .lat_wait   (state_q == ST_WAIT),
        .lat_direct (lat_direct),
        .lat_expire (lat_expire)
    );

    always_ff @(posedge DRP_CLK or negedge DRP_RST_N) begin
        if (!DRP_RST_N) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        lat_load = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (DRP_EN) begin
                    lat_load = 1'b1;
                    state_d  = lat_direct ? ST_RESP : ST_WAIT;
                end
            end
            ST_WAIT: if (lat_expire) state_d = ST_RESP;
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign accept  = (state_q == ST_IDLE) && DRP_EN;
    assign in_resp = (state_q == ST_RESP);

    // RO_ADDR wins even if a parameter choice places it inside the window.
    assign addr_off = addr_q - BASE_ADDR;
    assign idx      = addr_off[IDX_W-1:0];
    assign is_ro    = (addr_q == RO_ADDR);
    assign in_win   = !is_ro && (addr_q >= BASE_ADDR) && (addr_off < DEPTH8);

    always_comb begin
        rd_val = '0;
        if (is_ro)       rd_val = {9'd0, STAT_CRSCODE, 1'b0};
        else if (in_win) rd_val = bank[idx];
    end

    assign err_set[ERR_BUSY] = DRP_EN && (state_q != ST_IDLE);
    assign err_set[ERR_ADDR] = in_resp && !is_ro && !in_win;
    assign err_set[ERR_RO]   = in_resp && we_q && is_ro;

    always_ff @(posedge DRP_CLK or negedge DRP_RST_N) begin
        if (!DRP_RST_N) begin
            addr_q <= '0;
            di_q   <= '0;
            we_q   <= 1'b0;
            do_q   <= '0;
            err_q  <= '0;
            for (int i = 0; i < BANK_N; i++) bank[i] <= '0;
        end else begin
            if (accept) begin
                addr_q <= DRP_ADDR;
                di_q   <= DRP_DI;
                we_q   <= DRP_WE;
            end
            if (in_resp && !we_q)         do_q <= rd_val;
            if (in_resp && we_q && in_win) bank[idx] <= di_q;
            err_q <= (ERR_CLR ? '0 : err_q) | err_set;
        end
    end

    // Read data is presented in the RDY cycle itself, then held by do_q.
    assign DRP_DO   = (in_resp && !we_q) ? rd_val : do_q;
    assign DRP_RDY  = in_resp;
    assign DRP_ERR  = err_q;
    assign DRP_BUSY = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pcie_7x_v1_11_0_drp_resp.sv
// Directed bench for the DRP responder in its default (fixed latency) build.
module tb_pcie_7x_v1_11_0_drp_resp;

    logic        DRP_CLK = 1'b0;
    logic        DRP_RST_N = 1'b0;
    logic        DRP_EN = 1'b0;
    logic        DRP_WE = 1'b0;
    logic [7:0]  DRP_ADDR = 8'h00;
    logic [15:0] DRP_DI = 16'h0000;
    logic [15:0] DRP_DO;
    logic        DRP_RDY;
    logic [5:0]  STAT_CRSCODE = 6'h00;
    logic        ERR_CLR = 1'b0;
    logic [2:0]  DRP_ERR;
    logic        DRP_BUSY;

    int n_vec = 0;
    int n_err = 0;

    always #5 DRP_CLK = ~DRP_CLK;

    pcie_7x_v1_11_0_drp_resp dut (
        .DRP_CLK      (DRP_CLK),
        .DRP_RST_N    (DRP_RST_N),
        .DRP_EN       (DRP_EN),
        .DRP_WE       (DRP_WE),
        .DRP_ADDR     (DRP_ADDR),
        .DRP_DI       (DRP_DI),
        .DRP_DO       (DRP_DO),
        .DRP_RDY      (DRP_RDY),
        .STAT_CRSCODE (STAT_CRSCODE),
        .ERR_CLR      (ERR_CLR),
        .DRP_ERR      (DRP_ERR),
        .DRP_BUSY     (DRP_BUSY)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge DRP_CLK);
        #1;
    endtask

    // Pulse DRP_EN for one cycle; returns positioned 1ns into cycle t+1.
    task automatic drp_start(input logic we, input logic [7:0] addr, input logic [15:0] di);
        step();
        DRP_EN = 1'b1; DRP_WE = we; DRP_ADDR = addr; DRP_DI = di;
        step();
        DRP_EN = 1'b0; DRP_WE = 1'b0;
    endtask

    // Latency counted from the DRP_EN cycle; 0 means no RDY within the budget.
    task automatic drp_txn(input logic we, input logic [7:0] addr, input logic [15:0] di,
                           output int lat, output logic [15:0] dout);
        lat  = 0;
        dout = 16'hxxxx;
        drp_start(we, addr, di);
        for (int k = 1; k <= 20; k++) begin
            if (DRP_RDY) begin
                lat  = k;
                dout = DRP_DO;
                break;
            end
            step();
        end
        if (lat != 0) begin
            step();
            chk("rdy_one_cycle", {31'd0, DRP_RDY}, 32'd0);
        end
    endtask

    task automatic err_clear();
        step();
        ERR_CLR = 1'b1;
        step();
        ERR_CLR = 1'b0;
        chk("err_clr", {29'd0, DRP_ERR}, 32'd0);
    endtask

    int          lat;
    logic [15:0] d;
    int          rdy_cnt;
    logic [15:0] cap;

    initial begin
        #23;
        DRP_RST_N = 1'b1;
        step();
        chk("rst_do",   {16'd0, DRP_DO},   32'd0);
        chk("rst_rdy",  {31'd0, DRP_RDY},  32'd0);
        chk("rst_err",  {29'd0, DRP_ERR},  32'd0);
        chk("rst_busy", {31'd0, DRP_BUSY}, 32'd0);

        // Plain read of an untouched register
        drp_txn(1'b0, 8'h36, 16'h0, lat, d);
        chk("rd36_lat",  lat, 3);
        chk("rd36_data", {16'd0, d}, 32'h0000);
        chk("rd36_err",  {29'd0, DRP_ERR}, 32'd0);

        // Write then read back; DRP_DO must hold the last read across the write
        drp_txn(1'b1, 8'h36, 16'h0170, lat, d);
        chk("wr36_lat", lat, 2);
        chk("wr36_do_hold", {16'd0, DRP_DO}, 32'h0000);
        drp_txn(1'b0, 8'h36, 16'h0, lat, d);
        chk("rd36b_data", {16'd0, d}, 32'h0170);
        chk("rd36b_do_hold", {16'd0, DRP_DO}, 32'h0170);

        // Read-only CRS status word
        STAT_CRSCODE = 6'h2B;
        drp_txn(1'b0, 8'h88, 16'h0, lat, d);
        chk("rd88_lat",  lat, 3);
        chk("rd88_data", {16'd0, d}, 32'h0056);
        drp_txn(1'b1, 8'h88, 16'hFFFF, lat, d);
        chk("wr88_lat", lat, 2);
        chk("wr88_err", {29'd0, DRP_ERR}, 32'h4);
        drp_txn(1'b0, 8'h88, 16'h0, lat, d);
        chk("rd88b_data", {16'd0, d}, 32'h0056);
        err_clear();

        // Out-of-window accesses
        drp_txn(1'b0, 8'h50, 16'h0, lat, d);
        chk("rd50_data", {16'd0, d}, 32'h0000);
        chk("rd50_err",  {29'd0, DRP_ERR}, 32'h2);
        err_clear();
        drp_txn(1'b0, 8'h2F, 16'h0, lat, d);
        chk("rd2f_err", {29'd0, DRP_ERR}, 32'h2);
        err_clear();

        // Window edges: last register is writable, one past it is not
        drp_txn(1'b1, 8'h3F, 16'hA5C3, lat, d);
        chk("wr3f_err", {29'd0, DRP_ERR}, 32'd0);
        drp_txn(1'b1, 8'h40, 16'h1111, lat, d);
        chk("wr40_lat", lat, 2);
        chk("wr40_err", {29'd0, DRP_ERR}, 32'h2);
        err_clear();
        drp_txn(1'b0, 8'h3F, 16'h0, lat, d);
        chk("rd3f_data", {16'd0, d}, 32'hA5C3);
        drp_txn(1'b0, 8'h30, 16'h0, lat, d);
        chk("rd30_data", {16'd0, d}, 32'h0000);

        // DRP_EN while a read is in flight is dropped and flagged
        drp_txn(1'b1, 8'h31, 16'hBEEF, lat, d);
        drp_start(1'b0, 8'h31, 16'h0);
        chk("busy_flag", {31'd0, DRP_BUSY}, 32'd1);
        DRP_EN = 1'b1; DRP_WE = 1'b1; DRP_ADDR = 8'h31; DRP_DI = 16'h1234;
        step();
        DRP_EN = 1'b0; DRP_WE = 1'b0;
        rdy_cnt = 0;
        cap     = 16'h0;
        for (int k = 0; k < 10; k++) begin
            if (DRP_RDY) begin
                rdy_cnt++;
                cap = DRP_DO;
            end
            step();
        end
        chk("busy_rdy_cnt", rdy_cnt, 1);
        chk("busy_rd_data", {16'd0, cap}, 32'hBEEF);
        chk("busy_err", {29'd0, DRP_ERR}, 32'h1);
        err_clear();
        drp_txn(1'b0, 8'h31, 16'h0, lat, d);
        chk("rd31_after_busy", {16'd0, d}, 32'hBEEF);

        // Reset one cycle into a write aborts it
        drp_start(1'b1, 8'h32, 16'hFFFF);
        DRP_RST_N = 1'b0;
        step();
        DRP_RST_N = 1'b1;
        rdy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            if (DRP_RDY) rdy_cnt++;
            step();
        end
        chk("abort_rdy_cnt", rdy_cnt, 0);
        chk("abort_busy", {31'd0, DRP_BUSY}, 32'd0);
        drp_txn(1'b0, 8'h32, 16'h0, lat, d);
        chk("abort_rd32", {16'd0, d}, 32'h0000);
        drp_txn(1'b0, 8'h36, 16'h0, lat, d);
        chk("rst_clears_bank", {16'd0, d}, 32'h0000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/pcie_7x_v1_11_0_drp_resp.md
Name: pcie_7x_v1_11_0_drp_resp

Overview:
- DRP responder (slave end) of the GT DRP interface driven by the QPLL/CPLL DRP masters; provides a behavioural/soft register bank that accepts DRP read and write transactions and returns DRP_RDY/DRP_DO with programmable latency.
- Used as a stand-in GT DRP port in block-level benches and as a soft configuration register bank; checks protocol violations by the master.

Parameters:
- BASE_ADDR, 8'h30, first address of the read/write register window.
- DEPTH, 16, number of 16-bit read/write registers (window BASE_ADDR .. BASE_ADDR+DEPTH-1); legal range 1..64.
- RO_ADDR, 8'h88, address of the read-only status word (CRS code).
- RD_LATENCY, 4'd3, cycles from DRP_EN (read) to DRP_RDY; legal range 1..15.
- WR_LATENCY, 4'd2, cycles from DRP_EN (write) to DRP_RDY; legal range 1..15.

Ports:
- DRP_CLK  in  1  clock.
- DRP_RST_N  in  1  asynchronous active-low reset.
- DRP_EN  in  1  one-cycle transaction request.
- DRP_WE  in  1  write qualifier, sampled with DRP_EN.
- DRP_ADDR  in  8  address, sampled with DRP_EN.
- DRP_DI  in  16  write data, sampled with DRP_EN.
- DRP_DO  out  16  read data, valid when DRP_RDY=1.
- DRP_RDY  out  1  one-cycle completion pulse.
- STAT_CRSCODE  in  6  live status value exposed at RO_ADDR.
- ERR_CLR  in  1  synchronous clear of DRP_ERR.
- DRP_ERR  out  3  sticky errors: [0] DRP_EN while busy, [1] address outside window and not RO_ADDR, [2] write to RO_ADDR.
- DRP_BUSY  out  1  transaction outstanding.

Behaviour:
- Reset (async assert, sync deassert by usage): DRP_DO=0, DRP_RDY=0, DRP_ERR=0, DRP_BUSY=0, all bank registers=16'h0000, FSM=IDLE, latency counter=0.
- FSM states IDLE, WAIT, RESP.
- IDLE: DRP_EN=1 -> latch ADDR/DI/WE, load counter with (WE ? WR_LATENCY : RD_LATENCY)-1, go WAIT (or RESP directly if latency=1); DRP_BUSY=1 from the next cycle.
- WAIT: decrement counter; at 0 go RESP.
- RESP: DRP_RDY=1 for exactly this cycle; return to IDLE. Request with DRP_EN at cycle t -> DRP_RDY at cycle t+LAT.
- Back-to-back: DRP_EN in the cycle after RDY is accepted. DRP_EN during the RDY cycle itself counts as busy (error).
- Read: in RESP, DRP_DO = bank[addr-BASE_ADDR] if in window; {9'd0, STAT_CRSCODE, 1'b0} if addr==RO_ADDR (STAT_CRSCODE sampled in RESP cycle); 16'h0000 otherwise and set DRP_ERR[1]. DRP_DO holds its last value outside RESP.
- Write: commit to bank in RESP cycle (same cycle as RDY); DRP_DO unchanged. Write outside window -> no commit, DRP_ERR[1]. Write to RO_ADDR -> no commit, DRP_ERR[2]. RDY always issued.
- DRP_EN while BUSY: request ignored (no latch, in-flight transaction unaffected), DRP_ERR[0] set.
- Window check: (addr >= BASE_ADDR) && (addr - BASE_ADDR < DEPTH), 8-bit unsigned; RO_ADDR inside window takes RO precedence.
- ERR_CLR: clears DRP_ERR; an error event in the same cycle wins (bit set).
- Reset mid-transaction: transaction aborted, no RDY, no commit.

Optional Feature:
- Macro DRP_RESP_RAND_LAT_EN.
- Defined: 8-bit LFSR (x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset) advancing every cycle; at request acceptance LFSR[1:0] (0..3) added to the base latency, saturating at 15. Exercises masters' RDY-wait robustness.
- Undefined: fixed latency exactly RD_LATENCY/WR_LATENCY; no LFSR logic.

Decomposition:
- Package pcie_7x_v1_11_0_drp_pkg: FSM state encoding, DRP address/data widths, error bit indices, LFSR seed/taps, default latencies.
- One sub-module natural: pcie_7x_v1_11_0_drp_resp_lat (latency counter plus optional LFSR), outputting load/expire strobes; bank and FSM stay in top.

Test Plan:
- Reset, then read 8'h36 -> DRP_RDY exactly 3 cycles after DRP_EN, DRP_DO=16'h0000, DRP_ERR=0.
- Write 8'h36 DI=16'h0170, then read 8'h36 -> write RDY at t+2; read returns 16'h0170.
- STAT_CRSCODE=6'h2B, read 8'h88 -> DRP_DO=16'h0056; write 8'h88 -> RDY issued, DRP_ERR=3'b100, subsequent read still 16'h0056.
- Read 8'h50 -> DRP_DO=16'h0000, DRP_ERR[1]=1; ERR_CLR pulse -> DRP_ERR=0.
- DRP_EN during outstanding read of 8'h31 -> single RDY only, read data correct, DRP_ERR[0]=1.
- Assert DRP_RST_N low one cycle into a write of 8'h32 DI=16'hFFFF -> no RDY, read of 8'h32 after reset returns 16'h0000.
